// File: rtl/rc5_key_sched_ctrl_pkg.sv
// Shared types, RC5 magic constants and size derivations for the key-schedule controller.
package rc5_key_sched_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_L = 3'd1,
    INIT_S = 3'd2,
    MIX_RD = 3'd3,
    MIX_A  = 3'd4,
    MIX_B  = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam logic [31:0] RC5_P32 = 32'hB7E15163;
  localparam logic [31:0] RC5_Q32 = 32'h9E3779B9;

  function automatic int rc5_t(input int rounds);
    return 2 * (rounds + 1);
  endfunction

  // An empty key still needs one L word.
  function automatic int rc5_c(input int key_bytes, input int word_bytes);
    return (key_bytes == 0) ? 1 : key_bytes / word_bytes;
  endfunction

  function automatic int rc5_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int rc5_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rc5_key_sched_ctrl_rotl.sv
// Combinational w-bit rotate-left by a variable amount.
module rc5_rotl #(
  parameter int W = 32
) (
  input  logic [W-1:0]         din,
  input  logic [$clog2(W)-1:0] amt,
  output logic [W-1:0]         dout
);

  logic [2*W-1:0] dbl_s;

  // The upper half of the shifted doubled word is the rotated value.
  always_comb begin
    dbl_s = {din, din} << amt;
    dout  = dbl_s[2*W-1:W];
  end

endmodule

// File: rtl/rc5_key_sched_ctrl.sv
// RC5 key expansion sequencer: loads L from key bytes, initialises S, then mixes S and L.
module rc5_key_sched_ctrl
  import rc5_key_sched_ctrl_pkg::*;
#(
  parameter int           w  = 32,
  parameter int           u  = 4,
  parameter int           b  = 16,
  parameter int           r  = 12,
  parameter logic [w-1:0] pW = w'(RC5_P32),
  parameter logic [w-1:0] qW = w'(RC5_Q32)
) (
  input  logic                               clk1,
  input  logic                               rst,
  input  logic                               start,
  output logic [rc5_aw(b)-1:0]               key_address,
  input  logic [7:0]                         key_sub_i,
  output logic [rc5_aw(rc5_c(b, u))-1:0]     L_address,
  output logic                               L_we,
  output logic [w-1:0]                       L_sub_i_prima,
  input  logic [w-1:0]                       L_sub_i,
  output logic [rc5_aw(rc5_t(r))-1:0]        S_address,
  output logic                               S_we,
  output logic [w-1:0]                       S_sub_i_prima,
  input  logic [w-1:0]                       S_sub_i,
  output logic                               busy,
  output logic                               done
);

  localparam int t  = rc5_t(r);
  localparam int c  = rc5_c(b, u);
  localparam int n  = 3 * rc5_max(t, c);
  localparam int KW = rc5_aw(b);
  localparam int LW = rc5_aw(c);
  localparam int SW = rc5_aw(t);
  localparam int NW = rc5_aw(n);
  localparam int RW = $clog2(w);

  state_e        state_q, state_d;
  logic [w-1:0]  a_q, a_d;
  logic [w-1:0]  bw_q, bw_d;
  logic [w-1:0]  acc_q, acc_d;
  logic [w-1:0]  lcap_q, lcap_d;
  logic [w-1:0]  sum_q, sum_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] i_q, i_d;
  logic [LW-1:0] j_q, j_d;
  logic [NW-1:0] it_q, it_d;

  logic [w-1:0]  ab_sum_s;
  logic [w-1:0]  rot_in_s;
  logic [w-1:0]  rot_out_s;
  logic [RW-1:0] rot_amt_s;
  logic [SW-1:0] i_inc_s;
  logic [LW-1:0] j_inc_s;

  // One rotator serves both halves of an iteration: fixed 3 in MIX_A, A+B in MIX_B.
  always_comb begin
    ab_sum_s = a_q + bw_q;
    if (state_q == MIX_A) begin
      rot_in_s  = S_sub_i + ab_sum_s;
      rot_amt_s = RW'(3);
    end else begin
      rot_in_s  = lcap_q + ab_sum_s;
      rot_amt_s = ab_sum_s[RW-1:0];
    end
    i_inc_s = (i_q == SW'(t - 1)) ? '0 : i_q + SW'(1);
    j_inc_s = (j_q == LW'(c - 1)) ? '0 : j_q + LW'(1);
  end

  rc5_rotl #(
    .W (w)
  ) u_rotl (
    .din  (rot_in_s),
    .amt  (rot_amt_s),
    .dout (rot_out_s)
  );

  // Next state, datapath updates and key/L/S port drive for the current state.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    bw_d          = bw_q;
    acc_d         = acc_q;
    lcap_d        = lcap_q;
    sum_d         = sum_q;
    k_d           = k_q;
    i_d           = i_q;
    j_d           = j_q;
    it_d          = it_q;
    key_address   = '0;
    L_address     = '0;
    L_we          = 1'b0;
    L_sub_i_prima = '0;
    S_address     = '0;
    S_we          = 1'b0;
    S_sub_i_prima = '0;
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_L;
          a_d     = '0;
          bw_d    = '0;
          acc_d   = '0;
          sum_d   = pW;
          k_d     = KW'(b - 1);
          i_d     = '0;
          j_d     = '0;
          it_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end

      // Bytes arrive high index first, so each finished word is little-endian.
      LOAD_L: begin
        key_address = k_q;
        acc_d       = {acc_q[w-9:0], key_sub_i};
        if ((int'(k_q) % u) == 0) begin
          L_we          = 1'b1;
          L_address     = LW'(int'(k_q) / u);
          L_sub_i_prima = acc_d;
        end else begin
          L_we = 1'b0;
        end
        if (k_q == '0) begin
          state_d = INIT_S;
        end else begin
          k_d = k_q - KW'(1);
        end
      end

      INIT_S: begin
        S_we          = 1'b1;
        S_address     = i_q;
        S_sub_i_prima = sum_q;
        sum_d         = sum_q + qW;
        if (i_q == SW'(t - 1)) begin
          state_d = MIX_RD;
          i_d     = '0;
        end else begin
          i_d = i_q + SW'(1);
        end
      end

      MIX_RD: begin
        S_address = i_q;
        L_address = j_q;
        state_d   = MIX_A;
      end

      // S[i] and L[j] read data are both valid this cycle; L is held for MIX_B.
      MIX_A: begin
        S_we          = 1'b1;
        S_address     = i_q;
        S_sub_i_prima = rot_out_s;
        L_address     = j_q;
        a_d           = rot_out_s;
        lcap_d        = L_sub_i;
        state_d       = MIX_B;
      end

      MIX_B: begin
        L_we          = 1'b1;
        L_address     = j_q;
        L_sub_i_prima = rot_out_s;
        bw_d          = rot_out_s;
        i_d           = i_inc_s;
        j_d           = j_inc_s;
        if (it_q == NW'(n - 1)) begin
          state_d = DONE;
        end else begin
          it_d    = it_q + NW'(1);
          state_d = MIX_RD;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any expansion in flight.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      bw_q    <= '0;
      acc_q   <= '0;
      lcap_q  <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      it_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bw_q    <= bw_d;
      acc_q   <= acc_d;
      lcap_q  <= lcap_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      it_q    <= it_d;
    end
  end

endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
// Scoreboard bench for rc5_key_sched_ctrl: reference RC5 write trace, hand spot values, done timing, reset.
`timescale 1ns/1ps
module tb_rc5_key_sched_ctrl;

  localparam int LAT = 277;

  logic        clk1 = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  key_address;
  logic [7:0]  key_sub_i;
  logic [1:0]  L_address;
  logic        L_we;
  logic [31:0] L_sub_i_prima;
  logic [31:0] L_sub_i;
  logic [4:0]  S_address;
  logic        S_we;
  logic [31:0] S_sub_i_prima;
  logic [31:0] S_sub_i;
  logic        busy;
  logic        done;
  logic [78:0] outs_s;

  logic [7:0]  key_mem [16];
  logic [31:0] l_mem [4];
  logic [31:0] s_mem [32];
  logic [31:0] model_s [26];

  typedef struct packed { logic is_s; logic [7:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { int ord; logic is_s; logic [7:0] addr; logic [31:0] data; } spot_t;

  wr_t   exp_q[$];
  spot_t spot_q[$];
  int    done_q[$];
  int    n_total = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    wr_total = 0;
  int    run_base = 0;

  always #5 clk1 = ~clk1;

  rc5_key_sched_ctrl dut (
    .clk1          (clk1),
    .rst           (rst),
    .start         (start),
    .key_address   (key_address),
    .key_sub_i     (key_sub_i),
    .L_address     (L_address),
    .L_we          (L_we),
    .L_sub_i_prima (L_sub_i_prima),
    .L_sub_i       (L_sub_i),
    .S_address     (S_address),
    .S_we          (S_we),
    .S_sub_i_prima (S_sub_i_prima),
    .S_sub_i       (S_sub_i),
    .busy          (busy),
    .done          (done)
  );

  assign key_sub_i = key_mem[key_address];
  assign outs_s = {key_address, L_address, L_we, L_sub_i_prima, S_address, S_we, S_sub_i_prima, busy, done};

  // Synchronous-read RAMs for L and S.
  always @(posedge clk1) begin
    if (L_we) l_mem[L_address] <= L_sub_i_prima;
    L_sub_i <= l_mem[L_address];
    if (S_we) s_mem[S_address] <= S_sub_i_prima;
    S_sub_i <= s_mem[S_address];
  end

  initial forever begin
    @(posedge clk1);
    cyc++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  // Reference RC5-32/12/16 key expansion, recorded as the ordered list of RAM writes.
  task automatic build_model();
    logic [31:0] l [4];
    logic [31:0] s [26];
    logic [31:0] a;
    logic [31:0] bb;
    int i;
    int j;
    for (int q = 0; q < 4; q++) l[q] = 32'h0;
    for (int k = 15; k >= 0; k--) begin
      l[k/4] = (l[k/4] << 8) + {24'h0, key_mem[k]};
      if (k % 4 == 0) exp_q.push_back('{1'b0, 8'(k / 4), l[k/4]});
    end
    s[0] = 32'hB7E15163;
    for (int q = 1; q < 26; q++) s[q] = s[q-1] + 32'h9E3779B9;
    for (int q = 0; q < 26; q++) exp_q.push_back('{1'b1, 8'(q), s[q]});
    a = 32'h0; bb = 32'h0; i = 0; j = 0;
    for (int q = 0; q < 78; q++) begin
      a = rotl32(s[i] + a + bb, 5'd3);
      s[i] = a;
      exp_q.push_back('{1'b1, 8'(i), a});
      bb = rotl32(l[j] + a + bb, 5'(a + bb));
      l[j] = bb;
      exp_q.push_back('{1'b0, 8'(j), bb});
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
    for (int q = 0; q < 26; q++) model_s[q] = s[q];
  endtask

  // Monitor: pops the scoreboard on every RAM write and on every done pulse.
  initial begin
    wr_t   w_act;
    wr_t   w_exp;
    spot_t sp;
    forever begin
      @(negedge clk1);
      if (!rst) begin
        check("we_exclusive", 128'(S_we & L_we), 128'(0));
        if (S_we || L_we) begin
          w_act = '{S_we, S_we ? 8'(S_address) : 8'(L_address), S_we ? S_sub_i_prima : L_sub_i_prima};
          if (spot_q.size() > 0 && spot_q[0].ord == wr_total - run_base) begin
            sp = spot_q.pop_front();
            check("spot_write", 128'(w_act), 128'({sp.is_s, sp.addr, sp.data}));
          end
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got %0h expected no write", w_act);
          end else begin
            w_exp = exp_q.pop_front();
            check("write_trace", 128'(w_act), 128'(w_exp));
          end
          wr_total++;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
          end else begin
            check("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic add_spot(input int ord, input logic is_s, input logic [7:0] addr, input logic [31:0] data);
    spot_q.push_back('{ord, is_s, addr, data});
  endtask

  task automatic do_start();
    @(negedge clk1);
    run_base = wr_total;
    build_model();
    done_q.push_back(cyc + LAT);
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    #1 check("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic wait_idle(input string name);
    int waited = 0;
    while ((done_q.size() != 0 || exp_q.size() != 0) && waited < 400) begin
      @(negedge clk1);
      waited++;
    end
    #1;
    check({name, "_done_seen"}, 128'(done_q.size()), 128'(0));
    check({name, "_trace_drained"}, 128'(exp_q.size()), 128'(0));
    check({name, "_spots_drained"}, 128'(spot_q.size()), 128'(0));
    @(negedge clk1);
    #1 check({name, "_idle_after_done"}, 128'({busy, done}), 128'(0));
  endtask

  task automatic check_s_array();
    for (int q = 0; q < 26; q++) check("s_array", 128'(s_mem[q]), 128'(model_s[q]));
  endtask

  initial begin
    logic found;
    #1 rst = 1'b1;
    for (int k = 0; k < 16; k++) key_mem[k] = 8'(k);
    #1 check("reset_outputs", 128'(outs_s), 128'(0));
    repeat (3) @(negedge clk1);
    rst = 1'b0;

    // Key bytes 0x00..0x0F; a stray start mid-run must not move done.
    add_spot(0, 1'b0, 8'd3, 32'h0F0E0D0C);
    add_spot(3, 1'b0, 8'd0, 32'h03020100);
    add_spot(4, 1'b1, 8'd0, 32'hB7E15163);
    add_spot(5, 1'b1, 8'd1, 32'h5618CB1C);
    do_start();
    repeat (100) @(negedge clk1);
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    wait_idle("run1");
    check_s_array();

    // All-zero key: first mixing iteration values are known by hand.
    for (int k = 0; k < 16; k++) key_mem[k] = 8'h00;
    add_spot(4, 1'b1, 8'd0, 32'hB7E15163);
    add_spot(5, 1'b1, 8'd1, 32'h5618CB1C);
    add_spot(30, 1'b1, 8'd0, 32'hBF0A8B1D);
    add_spot(31, 1'b0, 8'd0, 32'hB7E15163);
    do_start();
    wait_idle("run2");
    check_s_array();

    // Reset during MIX_A, then a clean restart.
    for (int k = 0; k < 16; k++) key_mem[k] = 8'(k * 37 + 5);
    do_start();
    found = 1'b0;
    for (int q = 0; q < 200 && !found; q++) begin
      @(posedge clk1);
      #2;
      if (S_we && (wr_total - run_base) >= 40) found = 1'b1;
    end
    check("mix_a_reached", 128'(found), 128'(1));
    rst = 1'b1;
    #1 check("mid_reset_outputs", 128'(outs_s), 128'(0));
    exp_q.delete();
    spot_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk1);
    #1 check("reset_held_outputs", 128'(outs_s), 128'(0));
    rst = 1'b0;
    repeat (10) @(negedge clk1);
    #1 check("no_resume_busy", 128'(busy), 128'(0));
    do_start();
    wait_idle("run3");
    check_s_array();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rc5_key_sched_ctrl.md
RC5_KEY_SCHED_CTRL -- requirements
Module: rc5_key_sched_ctrl

Interface
REQ-001 Parameter w, 32: word width in bits, power of two.
REQ-002 Parameter u, 4: bytes per word, equal to w/8.
REQ-003 Parameter b, 16: key length in bytes, multiple of u.
REQ-004 Parameter r, 12: rounds; t = 2*(r+1) = 26 and c = b/u = 4 are derived localparams.
REQ-005 Parameter pW, 32'hB7E15163; parameter qW, 32'h9E3779B9: magic constants.
REQ-006 clk1  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to run a full key expansion.
REQ-009 key_address  out  clog2(b)  key byte index.
REQ-010 key_sub_i  in  8  key byte at key_address, valid combinationally in the same cycle.
REQ-011 L_address, L_we, L_sub_i_prima  out  clog2(c), 1, w  L RAM address, write enable, write data.
REQ-012 L_sub_i  in  w  L RAM read data, valid one cycle after L_address with L_we=0.
REQ-013 S_address, S_we, S_sub_i_prima  out  clog2(t), 1, w  S RAM address, write enable, write data.
REQ-014 S_sub_i  in  w  S RAM read data, valid one cycle after S_address with S_we=0.
REQ-015 busy, done  out  1, 1  high in every non-IDLE state; done is a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_L, INIT_S, MIX_RD, MIX_A, MIX_B and DONE.
REQ-017 start SHALL be sampled only in IDLE; start in any other state SHALL be ignored with no effect.
REQ-018 IDLE -> LOAD_L on start; A, B, the byte counter k=b-1, and i=j=0 SHALL load on that edge.
REQ-019 LOAD_L SHALL take b cycles, counting k from b-1 down to 0, with key_address=k and acc={acc[w-9:0], key_sub_i}.
REQ-020 In LOAD_L, when k mod u == 0, the block SHALL assert L_we with L_address=k/u and L_sub_i_prima equal to the shifted value (little-endian word).
REQ-021 INIT_S SHALL take t cycles: S_we=1, S_address=i, S_sub_i_prima=pW+i*qW mod 2^w, using a running-sum register with no multiplier.
REQ-022 The mixing loop SHALL run n = 3*max(t,c) iterations, each iteration being MIX_RD -> MIX_A -> MIX_B.
REQ-023 MIX_RD SHALL drive S_address=i and L_address=j with both write enables low.
REQ-024 MIX_A SHALL set A = rotl(S_sub_i+A+B, 3), write A to S[i], and capture L_sub_i.
REQ-025 MIX_B SHALL set B = rotl(Lcap+A+B, (A+B) mod w), write B to L[j], and advance i=(i+1) mod t, j=(j+1) mod c.
REQ-026 All additions SHALL be mod 2^w; the rotate amount SHALL use only the low clog2(w) bits.
REQ-027 After iteration n the FSM SHALL enter DONE, assert done for exactly one cycle, then return to IDLE.
REQ-028 Latency from the start edge to done high SHALL be b + t + 9*max(t,c) + 1 cycles (277 with the default parameters).
REQ-029 i and j SHALL wrap independently, and c=1 SHALL be legal with j held at 0.
REQ-030 At most one of S_we and L_we SHALL be high in any cycle, and both SHALL be low in IDLE and DONE.

Reset
REQ-031 rst SHALL immediately force IDLE and clear A, B, acc and all counters, including mid-operation.
REQ-032 While rst is high, all outputs SHALL be 0, including busy, done, both write enables, all addresses and all write data.
REQ-033 After rst deasserts, the block SHALL wait for a fresh start; a partial expansion SHALL never resume.

Structure
REQ-034 A shared package SHALL hold the state enum, the RC5 magic constants, and the t and c derivation functions.
REQ-035 The rotate-left by a variable amount SHALL be one sub-module, rc5_rotl (w-bit barrel shifter, combinational).

Verification
REQ-036 Key bytes K[k]=k (0x00..0x0F), then start -> L[0]=0x03020100 and L[3]=0x0F0E0D0C written during LOAD_L.
REQ-037 Any key, then start -> INIT_S writes S[0]=0xB7E15163 and S[1]=0x5618CB1C.
REQ-038 All-zero key -> first iteration writes S[0]=0xBF0A8B1D and then L[0]=0xB7E15163.
REQ-039 start pulse -> busy rises next cycle and done pulses exactly 277 cycles after start; a second start while busy does not change the done time.
REQ-040 rst asserted during MIX_A -> outputs go to 0 asynchronously and state is IDLE; a new start then reproduces the full reference S array.
REQ-041 Full run compared against a software RC5-32/12/16 model -> all 26 S words match.
